// File: rtl/video_pkg.sv
// rtl/video_pkg.sv - mode constants, timing helpers and colour-bar table for video_timing_gen
package video_pkg;

    typedef struct packed {
        int unsigned h_active;
        int unsigned h_fp;
        int unsigned h_sync;
        int unsigned h_bp;
        int unsigned v_active;
        int unsigned v_fp;
        int unsigned v_sync;
        int unsigned v_bp;
    } mode_t;

    localparam mode_t MODE_480P60 = '{640, 16, 96, 48, 480, 10, 2, 33};
    localparam mode_t MODE_600P60 = '{800, 40, 128, 88, 600, 1, 4, 23};
    localparam mode_t MODE_720P60 = '{1280, 110, 40, 220, 720, 5, 5, 20};

    function automatic int unsigned line_total(int unsigned act, int unsigned fp,
                                               int unsigned sync, int unsigned bp);
        return act + fp + sync + bp;
    endfunction

    // Bar index -> {B,G,R} channel enables
    localparam logic [2:0] BAR_RGB [8] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};

endpackage

// File: rtl/sync_delay.sv
// rtl/sync_delay.sv - reset-to-value shift register; DEPTH=0 is a plain wire bypass
module sync_delay #(
    parameter int         W       = 1,
    parameter int         DEPTH   = 1,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         i_clk,
    input  logic         i_resetn,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    generate
        if (DEPTH == 0) begin : g_bypass
            logic w_unused_clk;
            assign w_unused_clk = i_clk ^ i_resetn;
            assign o_q = i_d;
        end else begin : g_shift
            logic [W-1:0] r_stage [DEPTH];

            always_ff @(posedge i_clk or negedge i_resetn) begin
                if (!i_resetn) begin
                    for (int i = 0; i < DEPTH; i++) r_stage[i] <= RST_VAL;
                end else begin
                    r_stage[0] <= i_d;
                    for (int i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
                end
            end

            assign o_q = r_stage[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/video_timing_gen.sv
// rtl/video_timing_gen.sv - parametrised raster timing, pipeline-aligned sync/DE and VGA output register
module video_timing_gen
    import video_pkg::*;
#(
    parameter int unsigned H_ACTIVE = MODE_480P60.h_active,
    parameter int unsigned H_FP     = MODE_480P60.h_fp,
    parameter int unsigned H_SYNC   = MODE_480P60.h_sync,
    parameter int unsigned H_BP     = MODE_480P60.h_bp,
    parameter int unsigned V_ACTIVE = MODE_480P60.v_active,
    parameter int unsigned V_FP     = MODE_480P60.v_fp,
    parameter int unsigned V_SYNC   = MODE_480P60.v_sync,
    parameter int unsigned V_BP     = MODE_480P60.v_bp,
    parameter bit          H_POL    = 1'b0,
    parameter bit          V_POL    = 1'b0,
    parameter int          CW       = 10,
    parameter int          BPC      = 4,
    parameter int          PIPE_LAT = 2
) (
    input  logic           clk_pix,
    input  logic           resetn,
    input  logic           pattern_en,
    output logic [CW-1:0]  x,
    output logic [CW-1:0]  y,
    output logic           active,
    output logic           frame_start,
    output logic           line_start,
    input  logic [BPC-1:0] pix_r,
    input  logic [BPC-1:0] pix_g,
    input  logic [BPC-1:0] pix_b,
    output logic [BPC-1:0] vga_r,
    output logic [BPC-1:0] vga_g,
    output logic [BPC-1:0] vga_b,
    output logic           vga_hsync,
    output logic           vga_vsync,
    output logic           vga_de
);

    localparam int unsigned H_TOTAL  = line_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int unsigned V_TOTAL  = line_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int unsigned HS_START = H_ACTIVE + H_FP;
    localparam int unsigned HS_END   = HS_START + H_SYNC;
    localparam int unsigned VS_START = V_ACTIVE + V_FP;
    localparam int unsigned VS_END   = VS_START + V_SYNC;
    localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);
    localparam int DW = CW + 3;

    generate
        if (H_TOTAL > 2**CW || V_TOTAL > 2**CW) begin : g_cw_check
            $error("video_timing_gen: CW too narrow for H_TOTAL/V_TOTAL");
        end
    endgenerate

    logic [CW-1:0]  r_h;
    logic [CW-1:0]  r_v;
    logic           r_pat;
    logic [31:0]    w_h32;
    logic [31:0]    w_v32;
    logic           w_hs_int;
    logic           w_vs_int;
    logic [DW-1:0]  w_dl_in;
    logic [DW-1:0]  w_dl_out;
    logic [CW-1:0]  w_hd;
    logic           w_hs_d;
    logic           w_vs_d;
    logic           w_act_d;
    logic [2:0]     w_bar_idx;
    logic [2:0]     w_bar_rgb;
    logic [BPC-1:0] w_r;
    logic [BPC-1:0] w_g;
    logic [BPC-1:0] w_b;

    always_ff @(posedge clk_pix or negedge resetn) begin
        if (!resetn) begin
            r_h <= '0;
            r_v <= '0;
        end else if (r_h == H_LAST) begin
            r_h <= '0;
            r_v <= (r_v == V_LAST) ? '0 : r_v + 1'b1;
        end else begin
            r_h <= r_h + 1'b1;
        end
    end

    // Compare at 32 bits so a sync end equal to 2**CW cannot wrap
    assign w_h32       = 32'(r_h);
    assign w_v32       = 32'(r_v);
    assign x           = r_h;
    assign y           = r_v;
    assign active      = (w_h32 < H_ACTIVE) && (w_v32 < V_ACTIVE);
    assign line_start  = (r_h == '0);
    assign frame_start = (r_h == '0) && (r_v == '0);
    assign w_hs_int    = (w_h32 >= HS_START) && (w_h32 < HS_END);
    assign w_vs_int    = (w_v32 >= VS_START) && (w_v32 < VS_END);

    always_ff @(posedge clk_pix or negedge resetn) begin
        if (!resetn)          r_pat <= 1'b0;
        else if (frame_start) r_pat <= pattern_en;
    end

    assign w_dl_in = {w_hs_int, w_vs_int, active, r_h};

    sync_delay #(
        .W       (DW),
        .DEPTH   (PIPE_LAT),
        .RST_VAL ('0)
    ) u_sync_delay (
        .i_clk    (clk_pix),
        .i_resetn (resetn),
        .i_d      (w_dl_in),
        .o_q      (w_dl_out)
    );

    assign {w_hs_d, w_vs_d, w_act_d, w_hd} = w_dl_out;
    assign w_bar_idx = 3'((32'(w_hd) * 32'd8) / H_ACTIVE);
    assign w_bar_rgb = BAR_RGB[w_bar_idx];

    always_comb begin
        w_r = '0;
        w_g = '0;
        w_b = '0;
        if (w_act_d) begin
            if (r_pat) begin
                w_r = {BPC{w_bar_rgb[0]}};
                w_g = {BPC{w_bar_rgb[1]}};
                w_b = {BPC{w_bar_rgb[2]}};
            end else begin
                w_r = pix_r;
                w_g = pix_g;
                w_b = pix_b;
            end
        end
    end

    always_ff @(posedge clk_pix or negedge resetn) begin
        if (!resetn) begin
            vga_r     <= '0;
            vga_g     <= '0;
            vga_b     <= '0;
            vga_de    <= 1'b0;
            vga_hsync <= ~H_POL;
            vga_vsync <= ~V_POL;
        end else begin
            vga_r     <= w_r;
            vga_g     <= w_g;
            vga_b     <= w_b;
            vga_de    <= w_act_d;
            vga_hsync <= w_hs_d ? H_POL : ~H_POL;
            vga_vsync <= w_vs_d ? V_POL : ~V_POL;
        end
    end

endmodule

// File: tb/tb_video_timing_gen.sv
// tb/tb_video_timing_gen.sv - randomized colour/pattern stimulus against a cycle-count reference model
module tb_video_timing_gen;

    localparam int MAXK = 6000;

    logic       clk;
    logic       resetn;
    logic       pattern_en;
    logic [3:0] pix_r, pix_g, pix_b;

    logic [7:0] a_x, a_y;
    logic       a_act, a_fs, a_ls, a_hs, a_vs, a_de;
    logic [3:0] a_r, a_g, a_b;
    logic [3:0] s_x, s_y;
    logic       s_act, s_fs, s_ls, s_hs, s_vs, s_de;
    logic [3:0] s_r, s_g, s_b;

    int total = 0;
    int bad   = 0;

    int col_r [MAXK];
    int col_g [MAXK];
    int col_b [MAXK];
    int pen   [MAXK];
    logic pat_now;

    video_timing_gen #(
        .H_ACTIVE(64), .H_FP(4), .H_SYNC(8), .H_BP(4),
        .V_ACTIVE(12), .V_FP(2), .V_SYNC(2), .V_BP(3),
        .H_POL(1'b0), .V_POL(1'b0), .CW(8), .BPC(4), .PIPE_LAT(2)
    ) dut_a (
        .clk_pix(clk), .resetn(resetn), .pattern_en(pattern_en),
        .x(a_x), .y(a_y), .active(a_act), .frame_start(a_fs), .line_start(a_ls),
        .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b),
        .vga_r(a_r), .vga_g(a_g), .vga_b(a_b),
        .vga_hsync(a_hs), .vga_vsync(a_vs), .vga_de(a_de)
    );

    video_timing_gen #(
        .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .H_POL(1'b0), .V_POL(1'b0), .CW(4), .BPC(4), .PIPE_LAT(0)
    ) dut_s (
        .clk_pix(clk), .resetn(resetn), .pattern_en(pattern_en),
        .x(s_x), .y(s_y), .active(s_act), .frame_start(s_fs), .line_start(s_ls),
        .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b),
        .vga_r(s_r), .vga_g(s_g), .vga_b(s_b),
        .vga_hsync(s_hs), .vga_vsync(s_vs), .vga_de(s_de)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            if (bad <= 20) $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: after k clocks since reset release, raster position is k mod the
    // line/frame period; pins reflect position k-1-lat and the colour driven one clock earlier.
    task automatic check_mode(input string nm, input int ha, hf, hs, hb, va, vf, vs, vb, lat,
                              input int k, input logic [7:0] ox, oy,
                              input logic oact, ofs, ols, input logic [3:0] o_r, o_g, o_b,
                              input logic ohs, ovs, ode);
        int ht, vt, ft, h, v, c, m, idx;
        logic e_act, e_de, e_hs, e_vs, pat;
        logic [3:0] e_r, e_g, e_b;
        ht = ha + hf + hs + hb;
        vt = va + vf + vs + vb;
        ft = ht * vt;
        h = k % ht;
        v = (k / ht) % vt;
        check({nm, "_x"}, 32'(ox), 32'(h));
        check({nm, "_y"}, 32'(oy), 32'(v));
        check({nm, "_active"}, 32'(oact), 32'((h < ha) && (v < va)));
        check({nm, "_frame_start"}, 32'(ofs), 32'(k % ft == 0));
        check({nm, "_line_start"}, 32'(ols), 32'(h == 0));
        c = k - 1 - lat;
        e_de = 1'b0; e_hs = 1'b1; e_vs = 1'b1; e_r = '0; e_g = '0; e_b = '0;
        if (k >= 1 && c >= 0) begin
            h = c % ht;
            v = (c / ht) % vt;
            e_act = (h < ha) && (v < va);
            e_de = e_act;
            e_hs = !((h >= ha + hf) && (h < ha + hf + hs));
            e_vs = !((v >= va + vf) && (v < va + vf + vs));
            pat = 1'b0;
            if (k >= 2) begin
                m = ((k - 2) / ft) * ft;
                pat = pen[m][0];
            end
            if (e_act) begin
                if (pat) begin
                    idx = (h * 8) / ha;
                    e_r = idx[0] ? 4'hF : 4'h0;
                    e_g = idx[1] ? 4'hF : 4'h0;
                    e_b = idx[2] ? 4'hF : 4'h0;
                end else begin
                    e_r = 4'(col_r[k-1]);
                    e_g = 4'(col_g[k-1]);
                    e_b = 4'(col_b[k-1]);
                end
            end
        end
        check({nm, "_de"}, 32'(ode), 32'(e_de));
        check({nm, "_hsync"}, 32'(ohs), 32'(e_hs));
        check({nm, "_vsync"}, 32'(ovs), 32'(e_vs));
        check({nm, "_rgb"}, {20'd0, o_r, o_g, o_b}, {20'd0, e_r, e_g, e_b});
    endtask

    task automatic check_both(input int k);
        check_mode("a", 64, 4, 8, 4, 12, 2, 2, 3, 2, k, a_x, a_y, a_act, a_fs, a_ls,
                   a_r, a_g, a_b, a_hs, a_vs, a_de);
        check_mode("s", 8, 1, 2, 1, 4, 1, 1, 1, 0, k, {4'd0, s_x}, {4'd0, s_y}, s_act, s_fs, s_ls,
                   s_r, s_g, s_b, s_hs, s_vs, s_de);
    endtask

    task automatic drive(input int k);
        if (k % 1520 == 700) pat_now = ~pat_now;
        col_r[k] = int'($urandom_range(15, 0));
        col_g[k] = int'($urandom_range(15, 0));
        col_b[k] = int'($urandom_range(15, 0));
        pen[k]   = int'(pat_now);
        pix_r = 4'(col_r[k]);
        pix_g = 4'(col_g[k]);
        pix_b = 4'(col_b[k]);
        pattern_en = pat_now;
    endtask

    task automatic run(input int ncyc);
        check_both(0);
        drive(0);
        for (int k = 1; k <= ncyc; k++) begin
            @(negedge clk);
            check_both(k);
            drive(k);
        end
    endtask

    task automatic check_reset_values(input string nm);
        check({nm, "_a_pins"}, {26'd0, a_de, a_hs, a_vs, a_r == 4'd0, a_g == 4'd0, a_b == 4'd0},
              {26'd0, 6'b011111});
        check({nm, "_a_xy_fs"}, {15'd0, a_x, a_y, a_fs}, 32'd1);
        check({nm, "_s_pins"}, {26'd0, s_de, s_hs, s_vs, s_r == 4'd0, s_g == 4'd0, s_b == 4'd0},
              {26'd0, 6'b011111});
        check({nm, "_s_xy_fs"}, {23'd0, s_x, s_y, s_fs}, 32'd1);
    endtask

    initial begin
        resetn = 1'b0;
        pattern_en = 1'b0;
        pix_r = '0; pix_g = '0; pix_b = '0;
        pat_now = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_values("por");
        resetn = 1'b1;
        run(3 * 1520 + 7 * 80 + 30);

        // Mid-frame reset: asserted between edges, must act without a clock
        #2;
        resetn = 1'b0;
        #1;
        check_reset_values("async");
        repeat (5) @(posedge clk);
        @(negedge clk);
        check_reset_values("held");
        resetn = 1'b1;
        pat_now = 1'b0;
        run(2 * 1520 + 100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
